// File: rtl/axi4_stream_sync_fifo_if.sv
// axi4_stream_sync_fifo_if: tdata-only AXI4-Stream channel with master/slave views.
interface axi4_stream_sync_fifo_if #(parameter int DATA_SIZE = 8);
   logic [DATA_SIZE-1:0] tdata;
   logic                 tvalid;
   logic                 tready;
   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axi4_stream_sync_fifo.sv
// axi4_stream_sync_fifo: single-clock first-word-fall-through AXI4-Stream byte FIFO.
module axi4_stream_sync_fifo #(
   parameter int DATA_SIZE = 8,
   parameter int DEPTH     = 16
) (
   input logic                     clk_i,
   input logic                     rst_ni,
   axi4_stream_sync_fifo_if.slave  data_in,
   axi4_stream_sync_fifo_if.master data_out
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_SIZE-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wptr, r_rptr, w_rptr_nxt;
   logic [AW:0]          r_count, w_count_nxt;
   logic                 r_in_tready, r_out_tvalid, w_push, w_pop;
   logic [DATA_SIZE-1:0] r_out_tdata;
   always_comb begin
      w_push      = data_in.tvalid && r_in_tready;
      w_pop       = r_out_tvalid && data_out.tready;
      w_rptr_nxt  = w_pop ? r_rptr + 1'b1 : r_rptr;
      w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
   end
   always_ff @(posedge clk_i)
      if (w_push) r_mem[r_wptr] <= data_in.tdata;
   // Head is registered; when the next head is the beat being written now, take it from the input
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_in_tready  <= 1'b0;
         r_out_tvalid <= 1'b0;
         r_out_tdata  <= '0;
      end else begin
         r_wptr       <= w_push ? r_wptr + 1'b1 : r_wptr;
         r_rptr       <= w_rptr_nxt;
         r_count      <= w_count_nxt;
         r_in_tready  <= w_count_nxt < (AW+1)'(DEPTH);
         r_out_tvalid <= w_count_nxt != '0;
         r_out_tdata  <= (w_push && r_wptr == w_rptr_nxt) ? data_in.tdata : r_mem[w_rptr_nxt];
      end
   end
   assign data_in.tready  = r_in_tready;
   assign data_out.tvalid = r_out_tvalid;
   assign data_out.tdata  = r_out_tdata;
endmodule

// File: tb/tb_axi4_stream_sync_fifo.sv
// tb_axi4_stream_sync_fifo: directed and scoreboarded checks of the stream FIFO.
module tb_axi4_stream_sync_fifo;
   logic clk, rst_n;
   int   n_chk = 0, n_pass = 0;
   axi4_stream_sync_fifo_if #(.DATA_SIZE(8)) in_if ();
   axi4_stream_sync_fifo_if #(.DATA_SIZE(8)) out_if ();
   axi4_stream_sync_fifo #(.DATA_SIZE(8), .DEPTH(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data_in(in_if), .data_out(out_if)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [7:0] q[$];
      logic       in_acc, prev_hold;
      logic [7:0] prev_data;
      int         sent, cyc;
      rst_n = 1'b0;
      in_if.tvalid = 1'b0;
      in_if.tdata = '0;
      out_if.tready = 1'b0;
      #1;
      chk("rst_tdata", out_if.tdata, 0);
      for (int i = 0; i < 10; i++) begin
         chk("rst_tvalid", out_if.tvalid, 0);
         chk("rst_tready", in_if.tready, 0);
         step();
      end
      rst_n = 1'b1;
      chk("rel_tready_lag", in_if.tready, 0);
      step();
      chk("rel_tready", in_if.tready, 1);
      chk("rel_tvalid", out_if.tvalid, 0);
      // single beat
      in_if.tvalid = 1'b1;
      in_if.tdata = 8'hA5;
      out_if.tready = 1'b1;
      step();
      in_if.tvalid = 1'b0;
      chk("single_tvalid", out_if.tvalid, 1);
      chk("single_tdata", out_if.tdata, 8'hA5);
      step();
      chk("single_empty", out_if.tvalid, 0);
      // fill then drain
      out_if.tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("fill_tready", in_if.tready, 1);
         in_if.tvalid = 1'b1;
         in_if.tdata = 8'(i);
         step();
      end
      chk("full_tready", in_if.tready, 0);
      in_if.tdata = 8'h10;
      step();
      step();
      chk("full_hold_tready", in_if.tready, 0);
      in_if.tvalid = 1'b0;
      out_if.tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_tvalid", out_if.tvalid, 1);
         chk("drain_tdata", out_if.tdata, i);
         step();
         if (i == 0) chk("unfull_tready", in_if.tready, 1);
      end
      chk("drain_empty", out_if.tvalid, 0);
      // backpressure hold
      out_if.tready = 1'b0;
      in_if.tvalid = 1'b1;
      in_if.tdata = 8'h3C;
      step();
      in_if.tvalid = 1'b0;
      in_if.tdata = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_tvalid", out_if.tvalid, 1);
         chk("bp_tdata", out_if.tdata, 8'h3C);
         step();
      end
      out_if.tready = 1'b1;
      step();
      chk("bp_empty", out_if.tvalid, 0);
      // full-rate streaming across pointer wrap
      for (int i = 0; i < 40; i++) begin
         chk("stream_tready", in_if.tready, 1);
         in_if.tvalid = 1'b1;
         in_if.tdata = 8'(8'h40 + i);
         step();
         chk("stream_tvalid", out_if.tvalid, 1);
         chk("stream_tdata", out_if.tdata, 8'h40 + i);
      end
      in_if.tvalid = 1'b0;
      step();
      chk("stream_empty", out_if.tvalid, 0);
      // random stress with scoreboard
      sent = 0;
      cyc = 0;
      prev_hold = 1'b0;
      prev_data = '0;
      while (sent < 4096 && cyc < 60000) begin
         if (!in_if.tvalid) begin
            in_if.tvalid = $urandom_range(0, 9) < 6;
            in_if.tdata = 8'($urandom);
         end
         out_if.tready = $urandom_range(0, 1) == 1;
         if (prev_hold) begin
            chk("rnd_hold_tvalid", out_if.tvalid, 1);
            chk("rnd_hold_tdata", out_if.tdata, prev_data);
         end
         in_acc = in_if.tvalid && in_if.tready;
         if (in_acc) begin
            q.push_back(in_if.tdata);
            sent++;
         end
         if (out_if.tvalid && out_if.tready) begin
            chk("rnd_not_spurious", q.size() != 0, 1);
            if (q.size() != 0) chk("rnd_order", out_if.tdata, q.pop_front());
         end
         prev_hold = out_if.tvalid && !out_if.tready;
         prev_data = out_if.tdata;
         step();
         cyc++;
         if (in_acc) in_if.tvalid = 1'b0;
      end
      chk("rnd_sent", sent, 4096);
      in_if.tvalid = 1'b0;
      out_if.tready = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 100) begin
         if (out_if.tvalid) chk("rnd_drain", out_if.tdata, q.pop_front());
         step();
         cyc++;
      end
      chk("rnd_left", q.size(), 0);
      chk("rnd_empty", out_if.tvalid, 0);
      // asynchronous reset mid-stream
      out_if.tready = 1'b0;
      in_if.tvalid = 1'b1;
      in_if.tdata = 8'h77;
      step();
      step();
      step();
      in_if.tvalid = 1'b0;
      chk("mid_pre_tvalid", out_if.tvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", out_if.tvalid, 0);
      chk("mid_rst_tready", in_if.tready, 0);
      chk("mid_rst_tdata", out_if.tdata, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_rel_tready", in_if.tready, 1);
      chk("mid_rel_tvalid", out_if.tvalid, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
